div_ctrl: RTL and testbench

Multi-cycle divide sequencer for the execute stage of the MIPS core. It accepts DIV/DIVU operands from EX and runs a WIDTH-step restoring division. While busy it holds the pipeline stall request, then returns {remainder, quotient} for the HI/LO write. Flushes (jump/exception) cancel an in-flight division through `annul_i`.

---
 rtl/div_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_div_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl
//
// Multi-cycle divide sequencer for the execute stage. Accepts DIV/DIVU
// operands, runs a WIDTH-step restoring division (one step per cycle) and
// returns {remainder, quotient} for the HI/LO write. While a request is
// pending the pipeline stall request is held. A flush (annul_i) cancels an
// in-flight division.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start_i      divide request, held high until ready_o is seen
//   signed_i     1 = signed (DIV), 0 = unsigned (DIVU), sampled in IDLE
//   dividend_i   dividend, sampled in IDLE
//   divisor_i    divisor, sampled in IDLE
//   annul_i      cancel request (pipeline flush)
//   stall_req_o  stall request to the pipeline controller (combinational)
//   ready_o      result valid (registered)
//   result_o     {remainder, quotient}, zero unless ready_o is high
// ---------------------------------------------------------------------------
module div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     dividend_i,
  input  logic [WIDTH-1:0]     divisor_i,
  input  logic                 annul_i,
  output logic                 stall_req_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ZERO = 2'd1,
    ST_ON   = 2'd2,
    ST_END  = 2'd3
  } state_e;

  // Two's complement negation, wrapping modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] v);
    neg_val = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of a two's complement value; the most negative value maps to
  // itself, which is still the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      abs_val = neg_val(v);
    end else begin
      abs_val = v;
    end
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 ready_q, ready_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  // Restoring-step datapath: shift {rem, quo} left, trial subtract.
  logic [WIDTH:0]       rem_sh_s;
  logic [WIDTH:0]       trial_s;
  logic                 step_ok_s;
  logic [WIDTH-1:0]     rem_step_s;
  logic [WIDTH-1:0]     quo_step_s;
  logic [WIDTH-1:0]     quo_fix_s;
  logic [WIDTH-1:0]     rem_fix_s;

  // One division step: the trial difference fits in WIDTH+1 bits because
  // the shifted remainder is always below 2*divisor.
  always_comb begin
    rem_sh_s   = {rem_q, quo_q[WIDTH-1]};
    trial_s    = rem_sh_s - {1'b0, dvs_q};
    step_ok_s  = ~trial_s[WIDTH];
    if (step_ok_s) begin
      rem_step_s = trial_s[WIDTH-1:0];
    end else begin
      rem_step_s = rem_sh_s[WIDTH-1:0];
    end
    quo_step_s = {quo_q[WIDTH-2:0], step_ok_s};
    if (neg_quo_q) begin
      quo_fix_s = neg_val(quo_step_s);
    end else begin
      quo_fix_s = quo_step_s;
    end
    if (neg_rem_q) begin
      rem_fix_s = neg_val(rem_step_s);
    end else begin
      rem_fix_s = rem_step_s;
    end
  end

  // Next-state and register-update logic for the sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = ready_q;
    result_d  = result_q;

    case (state_q)
      ST_IDLE: begin
        ready_d  = 1'b0;
        result_d = {(2*WIDTH){1'b0}};
        if (start_i && !annul_i) begin
          cnt_d = {CNT_W{1'b0}};
          rem_d = {WIDTH{1'b0}};
          if (signed_i) begin
            quo_d     = abs_val(dividend_i);
            dvs_d     = abs_val(divisor_i);
            neg_quo_d = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
            neg_rem_d = dividend_i[WIDTH-1];
          end else begin
            quo_d     = dividend_i;
            dvs_d     = divisor_i;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
          end
          if (divisor_i == {WIDTH{1'b0}}) begin
            state_d = ST_ZERO;
          end else begin
            state_d = ST_ON;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ZERO: begin
        // Divide-by-zero result is pinned at 0.
        result_d = {(2*WIDTH){1'b0}};
        if (annul_i) begin
          state_d = ST_IDLE;
          ready_d = 1'b0;
        end else begin
          state_d = ST_END;
          ready_d = 1'b1;
        end
      end

      ST_ON: begin
        if (annul_i) begin
          state_d  = ST_IDLE;
          ready_d  = 1'b0;
          result_d = {(2*WIDTH){1'b0}};
        end else begin
          rem_d = rem_step_s;
          quo_d = quo_step_s;
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            // Last step: sign correction is applied on the way into END.
            state_d  = ST_END;
            ready_d  = 1'b1;
            result_d = {rem_fix_s, quo_fix_s};
          end else begin
            state_d = ST_ON;
          end
        end
      end

      ST_END: begin
        if (annul_i || !start_i) begin
          state_d  = ST_IDLE;
          ready_d  = 1'b0;
          result_d = {(2*WIDTH){1'b0}};
        end else begin
          state_d = ST_END;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        ready_d  = 1'b0;
        result_d = {(2*WIDTH){1'b0}};
      end
    endcase
  end

  // State, datapath and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      rem_q     <= {WIDTH{1'b0}};
      quo_q     <= {WIDTH{1'b0}};
      dvs_q     <= {WIDTH{1'b0}};
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= {(2*WIDTH){1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  // Stall is raised in the same cycle as the request; it is gated by reset
  // so that all outputs drop immediately while rst is low.
  assign stall_req_o = rst & start_i & ~annul_i & (state_q != ST_END);
  assign ready_o     = ready_q;
  assign result_o    = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        annul_i;
  logic        stall_req_o;
  logic        ready_o;
  logic [63:0] result_o;

  int total = 0;
  int bad   = 0;

  div_ctrl #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .annul_i     (annul_i),
    .stall_req_o (stall_req_o),
    .ready_o     (ready_o),
    .result_o    (result_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain 64-bit arithmetic (truncating division, remainder takes
  // the dividend's sign); divide-by-zero defined as 0.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue a request at cycle 0 (caller is 1 time unit after a rising edge)
  // and wait for ready_o. Returns the cycle of ready, the result, and whether
  // stall/result behaved (stall high and result zero before ready, stall low
  // at ready). Operands are scrambled after cycle 0. start_i left high.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                        output int lat, output logic [63:0] res, output bit beh_ok);
    start_i = 1'b1; signed_i = s; dividend_i = a; divisor_i = b; annul_i = 1'b0;
    lat = -1; res = 64'd0; beh_ok = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (ready_o) begin
        lat = c;
        res = result_o;
        if (stall_req_o !== 1'b0) beh_ok = 1'b0;
        break;
      end else if (stall_req_o !== 1'b1 || result_o !== 64'd0) begin
        beh_ok = 1'b0;
      end
      @(posedge clk); #1;
      dividend_i = $urandom; divisor_i = $urandom; signed_i = $urandom_range(0, 1);
    end
  endtask

  task automatic finish_op();
    start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b1; signed_i = 1'b0; annul_i = 1'b0;
    dividend_i = 32'd100; divisor_i = 32'd7;
    #2;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0 || stall_req_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b result=%h stall=%b, required 0/0/0", ready_o, result_o, stall_req_o);
    end
    repeat (3) @(posedge clk);
    #1;
    start_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ready_o !== 1'b0 || stall_req_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: ready=%b stall=%b, required 0/0", ready_o, stall_req_o);
    end
  endtask

  task automatic test_unsigned();
    int lat; logic [63:0] res; bit ok;
    run_op(32'd100, 32'd7, 1'b0, lat, res, ok);
    total++;
    if (lat !== 33) begin bad++; $display("FAIL u100_7_latency: got %0d, required 33", lat); end
    total++;
    if (res !== 64'h00000002_0000000E) begin bad++; $display("FAIL u100_7_result: got %h, required 000000020000000e", res); end
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL u100_7_stall: got behaviour flag %b, required 1", ok); end
    // hold start: result must stay stable
    repeat (2) begin @(posedge clk); #1; end
    total++;
    if (ready_o !== 1'b1 || result_o !== 64'h00000002_0000000E) begin
      bad++; $display("FAIL u100_7_hold: ready=%b result=%h, required 1/000000020000000e", ready_o, result_o);
    end
    finish_op();
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++; $display("FAIL u100_7_drop: ready=%b result=%h, required 0/0", ready_o, result_o);
    end
  endtask

  task automatic test_signed();
    int lat; logic [63:0] res; bit ok;
    run_op(32'hFFFFFFF9, 32'h2, 1'b1, lat, res, ok);
    total++;
    if (lat !== 33 || res !== 64'hFFFFFFFF_FFFFFFFD) begin
      bad++; $display("FAIL s_m7_2: lat=%0d result=%h, required 33/fffffffffffffffd", lat, res);
    end
    finish_op();
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, res, ok);
    total++;
    if (lat !== 33 || res !== 64'h00000000_80000000) begin
      bad++; $display("FAIL s_minint_m1: lat=%0d result=%h, required 33/0000000080000000", lat, res);
    end
    finish_op();
  endtask

  task automatic test_div_zero();
    int lat; logic [63:0] res; bit ok;
    for (int m = 0; m < 2; m++) begin
      run_op($urandom, 32'd0, m[0], lat, res, ok);
      total++;
      if (lat !== 2 || res !== 64'd0 || ok !== 1'b1) begin
        bad++; $display("FAIL div_zero_m%0d: lat=%0d result=%h ok=%b, required 2/0/1", m, lat, res, ok);
      end
      finish_op();
    end
  endtask

  task automatic test_annul();
    int lat; logic [63:0] res; bit ok; bit seen;
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'hFFFFFFFF; divisor_i = 32'd3; annul_i = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    annul_i = 1'b1;
    @(negedge clk);
    total++;
    if (stall_req_o !== 1'b0) begin bad++; $display("FAIL annul_c10_stall: got %b, required 0", stall_req_o); end
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    total++;
    if (stall_req_o !== 1'b0 || ready_o !== 1'b0) begin
      bad++; $display("FAIL annul_c11: stall=%b ready=%b, required 0/0", stall_req_o, ready_o);
    end
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (ready_o !== 1'b0) seen = 1'b1; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL annul_no_ready: ready pulsed=%b, required 0", seen); end
    @(posedge clk); #1;
    run_op(32'd9, 32'd3, 1'b0, lat, res, ok);
    total++;
    if (lat !== 33 || res !== 64'h00000000_00000003) begin
      bad++; $display("FAIL annul_then_9_3: lat=%0d result=%h, required 33/0000000000000003", lat, res);
    end
    // annul while in END
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++; $display("FAIL annul_end: ready=%b result=%h, required 0/0", ready_o, result_o);
    end
    // annul while in ZERO
    start_i = 1'b1; divisor_i = 32'd0; dividend_i = 32'd5;
    @(posedge clk); #1;
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    total++;
    if (ready_o !== 1'b0) begin bad++; $display("FAIL annul_zero: ready=%b, required 0", ready_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat; logic [63:0] res; bit ok;
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7; annul_i = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    #1 rst = 1'b0;
    #1;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0 || stall_req_o !== 1'b0) begin
      bad++; $display("FAIL reset_mid: ready=%b result=%h stall=%b, required 0/0/0", ready_o, result_o, stall_req_o);
    end
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    run_op(32'd100, 32'd7, 1'b0, lat, res, ok);
    total++;
    if (lat !== 33 || res !== 64'h00000002_0000000E || ok !== 1'b1) begin
      bad++; $display("FAIL reset_mid_rerun: lat=%0d result=%h ok=%b, required 33/000000020000000e/1", lat, res, ok);
    end
    finish_op();
  endtask

  // Back-to-back random requests, each starting in the first IDLE cycle.
  task automatic test_random();
    int lat; logic [63:0] res; bit ok;
    logic [31:0] a, b; bit s; logic [63:0] exp_res; int exp_lat;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      s = $urandom_range(0, 1);
      exp_res = model(a, b, s);
      exp_lat = (b == 32'd0) ? 2 : 33;
      run_op(a, b, s, lat, res, ok);
      total++;
      if (lat !== exp_lat || res !== exp_res || ok !== 1'b1) begin
        bad++;
        $display("FAIL random_%0d: a=%h b=%h s=%b lat=%0d result=%h ok=%b, required lat=%0d result=%h ok=1",
                 i, a, b, s, lat, res, ok, exp_lat, exp_res);
      end
      finish_op();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
